// File: rtl/neuron_ram_run_controller_pkg.sv
// Shared definitions for the neuron RAM run controller: run-state encoding and read owner tags.
package neuron_ram_run_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } run_state_e;

  localparam logic OWN_HOST = 1'b0;
  localparam logic OWN_ENG  = 1'b1;

  function automatic logic engine_owns_ram(input run_state_e st);
    return (st == ST_LAUNCH) || (st == ST_RUN);
  endfunction

endpackage

// File: rtl/neuron_ram_port_mux.sv
// Single-port RAM arbiter: one op per cycle, combinational grant, registered owner tag
// that routes the 1-cycle-latency read data back to whoever issued the read.
module neuron_ram_port_mux
  import neuron_ram_run_controller_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              eng_owner_i,
  input  logic              host_wr_en_i,
  input  logic [ADDR_W-1:0] host_wr_adr_i,
  input  logic [DATA_W-1:0] host_wr_data_i,
  input  logic              host_rd_en_i,
  input  logic [ADDR_W-1:0] host_rd_adr_i,
  output logic              host_stall_o,
  output logic [DATA_W-1:0] host_rd_data_o,
  output logic              host_rd_valid_o,
  input  logic              eng_req_i,
  input  logic              eng_we_i,
  input  logic [ADDR_W-1:0] eng_adr_i,
  input  logic [DATA_W-1:0] eng_wdata_i,
  output logic              eng_gnt_o,
  output logic [DATA_W-1:0] eng_rd_data_o,
  output logic              eng_rd_valid_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_adr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  logic eng_win;
  logic rd_pend_q, rd_pend_d;
  logic rd_owner_q, rd_owner_d;

  always_comb begin
    eng_win      = eng_owner_i & eng_req_i;
    eng_gnt_o    = eng_win;
    // A simultaneous host write+read always lets the write through first.
    host_stall_o = eng_win ? (host_wr_en_i | host_rd_en_i) : (host_wr_en_i & host_rd_en_i);
    ram_we_o     = 1'b0;
    ram_adr_o    = '0;
    ram_wdata_o  = '0;
    rd_pend_d    = 1'b0;
    rd_owner_d   = OWN_HOST;
    if (eng_win) begin
      ram_we_o    = eng_we_i;
      ram_adr_o   = eng_adr_i;
      ram_wdata_o = eng_wdata_i;
      rd_pend_d   = ~eng_we_i;
      rd_owner_d  = OWN_ENG;
    end else if (host_wr_en_i) begin
      ram_we_o    = 1'b1;
      ram_adr_o   = host_wr_adr_i;
      ram_wdata_o = host_wr_data_i;
    end else if (host_rd_en_i) begin
      ram_adr_o   = host_rd_adr_i;
      rd_pend_d   = 1'b1;
      rd_owner_d  = OWN_HOST;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= OWN_HOST;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign host_rd_valid_o = rd_pend_q & (rd_owner_q == OWN_HOST);
  assign eng_rd_valid_o  = rd_pend_q & (rd_owner_q == OWN_ENG);
  assign host_rd_data_o  = host_rd_valid_o ? ram_rdata_i : '0;
  assign eng_rd_data_o   = eng_rd_valid_o ? ram_rdata_i : '0;

endmodule

// File: rtl/neuron_ram_run_controller.sv
// Run sequencer for the accelerator core: start/launch/run/done FSM, RUN watchdog,
// result-window latches, and the shared neuron RAM port mux.
//
// state  | meaning
// IDLE   | no run since reset; host owns RAM
// LAUNCH | one-cycle engine launch pulse; engine owns RAM
// RUN    | engine busy, watchdog counting; engine owns RAM
// DONE   | run finished or aborted; host owns RAM, results held
module neuron_ram_run_controller
  import neuron_ram_run_controller_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              host_wr_en_i,
  input  logic [ADDR_W-1:0] host_wr_adr_i,
  input  logic [DATA_W-1:0] host_wr_data_i,
  input  logic              host_rd_en_i,
  input  logic [ADDR_W-1:0] host_rd_adr_i,
  output logic              host_stall_o,
  output logic [DATA_W-1:0] host_rd_data_o,
  output logic              host_rd_valid_o,
  output logic              finished_o,
  output logic              timeout_err_o,
  output logic [ADDR_W-1:0] result_base_address_o,
  output logic [ADDR_W-1:0] result_word_count_o,
  output logic              eng_start_o,
  input  logic              eng_done_i,
  input  logic [ADDR_W-1:0] eng_result_base_i,
  input  logic [ADDR_W-1:0] eng_result_count_i,
  input  logic              eng_req_i,
  input  logic              eng_we_i,
  input  logic [ADDR_W-1:0] eng_adr_i,
  input  logic [DATA_W-1:0] eng_wdata_i,
  output logic              eng_gnt_o,
  output logic [DATA_W-1:0] eng_rd_data_o,
  output logic              eng_rd_valid_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_adr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  run_state_e        state_q, state_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              finished_q, finished_d;
  logic              timeout_q, timeout_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic              wd_expired;

  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    finished_d  = finished_q;
    timeout_d   = timeout_q;
    base_d      = base_q;
    count_d     = count_q;
    eng_start_o = 1'b0;
    wd_expired  = (TIMEOUT > 0) && (wd_q == WD_LAST);
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d    = ST_LAUNCH;
          finished_d = 1'b0;
          timeout_d  = 1'b0;
        end
      end
      ST_LAUNCH: begin
        eng_start_o = 1'b1;
        wd_d        = '0;
        if (eng_done_i) begin
          state_d    = ST_DONE;
          finished_d = 1'b1;
          base_d     = eng_result_base_i;
          count_d    = eng_result_count_i;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (wd_q != '1) wd_d = wd_q + 1'b1;
        // A completion on the watchdog's last cycle still counts as a clean finish.
        if (eng_done_i) begin
          state_d    = ST_DONE;
          finished_d = 1'b1;
          base_d     = eng_result_base_i;
          count_d    = eng_result_count_i;
        end else if (wd_expired) begin
          state_d    = ST_DONE;
          finished_d = 1'b1;
          timeout_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      wd_q       <= '0;
      finished_q <= 1'b0;
      timeout_q  <= 1'b0;
      base_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      wd_q       <= wd_d;
      finished_q <= finished_d;
      timeout_q  <= timeout_d;
      base_q     <= base_d;
      count_q    <= count_d;
    end
  end

  assign finished_o            = finished_q;
  assign timeout_err_o         = timeout_q;
  assign result_base_address_o = base_q;
  assign result_word_count_o   = count_q;

  neuron_ram_port_mux #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_port_mux (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .eng_owner_i    (engine_owns_ram(state_q)),
    .host_wr_en_i   (host_wr_en_i),
    .host_wr_adr_i  (host_wr_adr_i),
    .host_wr_data_i (host_wr_data_i),
    .host_rd_en_i   (host_rd_en_i),
    .host_rd_adr_i  (host_rd_adr_i),
    .host_stall_o   (host_stall_o),
    .host_rd_data_o (host_rd_data_o),
    .host_rd_valid_o(host_rd_valid_o),
    .eng_req_i      (eng_req_i),
    .eng_we_i       (eng_we_i),
    .eng_adr_i      (eng_adr_i),
    .eng_wdata_i    (eng_wdata_i),
    .eng_gnt_o      (eng_gnt_o),
    .eng_rd_data_o  (eng_rd_data_o),
    .eng_rd_valid_o (eng_rd_valid_o),
    .ram_we_o       (ram_we_o),
    .ram_adr_o      (ram_adr_o),
    .ram_wdata_o    (ram_wdata_o),
    .ram_rdata_i    (ram_rdata_i)
  );

endmodule

// File: tb/tb_neuron_ram_run_controller.sv
// Bench for neuron_ram_run_controller: directed scenarios plus randomized runs and RAM
// traffic checked against a golden memory image and the run rules (TIMEOUT = 16).
module tb_neuron_ram_run_controller;

  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start;
  logic       host_wr_en, host_rd_en;
  logic [7:0] host_wr_adr, host_wr_data, host_rd_adr;
  logic       host_stall, host_rd_valid;
  logic [7:0] host_rd_data;
  logic       finished, timeout_err, eng_start;
  logic [7:0] rba, rwc;
  logic       eng_done, eng_req, eng_we, eng_gnt, eng_rd_valid;
  logic [7:0] eng_result_base, eng_result_count, eng_adr, eng_wdata, eng_rd_data;
  logic       ram_we;
  logic [7:0] ram_adr, ram_wdata, ram_rdata;

  neuron_ram_run_controller #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TO)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start),
    .host_wr_en_i(host_wr_en), .host_wr_adr_i(host_wr_adr), .host_wr_data_i(host_wr_data),
    .host_rd_en_i(host_rd_en), .host_rd_adr_i(host_rd_adr),
    .host_stall_o(host_stall), .host_rd_data_o(host_rd_data), .host_rd_valid_o(host_rd_valid),
    .finished_o(finished), .timeout_err_o(timeout_err),
    .result_base_address_o(rba), .result_word_count_o(rwc),
    .eng_start_o(eng_start), .eng_done_i(eng_done),
    .eng_result_base_i(eng_result_base), .eng_result_count_i(eng_result_count),
    .eng_req_i(eng_req), .eng_we_i(eng_we), .eng_adr_i(eng_adr), .eng_wdata_i(eng_wdata),
    .eng_gnt_o(eng_gnt), .eng_rd_data_o(eng_rd_data), .eng_rd_valid_o(eng_rd_valid),
    .ram_we_o(ram_we), .ram_adr_o(ram_adr), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  // Synchronous RAM with one cycle read latency
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (ram_we) mem[ram_adr] <= ram_wdata;
    ram_rdata <= mem[ram_adr];
  end

  logic [7:0] gm [256];
  int n_tests = 0, n_fail = 0;
  logic [7:0] exp_base = 8'h00, exp_count = 8'h00;
  int pend_kind = 0;
  logic [7:0] pend_data = 8'h00;

  task automatic drive_idle();
    start = 0; host_wr_en = 0; host_rd_en = 0; host_wr_adr = 0; host_wr_data = 0; host_rd_adr = 0;
    eng_done = 0; eng_result_base = 0; eng_result_count = 0;
    eng_req = 0; eng_we = 0; eng_adr = 0; eng_wdata = 0;
  endtask

  task automatic test_reset();
    reset = 1; drive_idle();
    repeat (3) @(negedge clk);
    reset = 0;
    n_tests++; if ({finished, timeout_err, eng_start, host_rd_valid, eng_rd_valid, host_stall, eng_gnt, ram_we} !== 8'h00) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 00000000", {finished, timeout_err, eng_start, host_rd_valid, eng_rd_valid, host_stall, eng_gnt, ram_we}); end
    n_tests++; if ({rba, rwc} !== 16'h0000) begin
      n_fail++; $display("FAIL reset_results: got %h expected 0000", {rba, rwc}); end
  endtask

  task automatic test_host_basic();
    @(negedge clk); host_wr_en = 1; host_wr_adr = 8'h05; host_wr_data = 8'h11; #1;
    n_tests++; if ({host_stall, ram_we, ram_adr, ram_wdata} !== {1'b0, 1'b1, 8'h05, 8'h11}) begin
      n_fail++; $display("FAIL host_write: got stall=%b we=%b adr=%h wd=%h expected 0 1 05 11", host_stall, ram_we, ram_adr, ram_wdata); end
    gm[5] = 8'h11;
    @(negedge clk); host_wr_en = 0; host_rd_en = 1; host_rd_adr = 8'h05; #1;
    n_tests++; if ({host_stall, ram_we} !== 2'b00) begin
      n_fail++; $display("FAIL host_read_grant: got stall=%b we=%b expected 0 0", host_stall, ram_we); end
    @(negedge clk); host_rd_en = 0;
    n_tests++; if ({host_rd_valid, eng_rd_valid, host_rd_data} !== {2'b10, 8'h11}) begin
      n_fail++; $display("FAIL host_read_return: got hv=%b ev=%b data=%h expected 1 0 11", host_rd_valid, eng_rd_valid, host_rd_data); end
    @(negedge clk);
    n_tests++; if (host_rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL host_read_single: got valid=%b expected 0", host_rd_valid); end
  endtask

  task automatic test_wr_rd_together();
    @(negedge clk); host_wr_en = 1; host_wr_adr = 8'h20; host_wr_data = 8'h5A; host_rd_en = 1; host_rd_adr = 8'h20; #1;
    n_tests++; if ({host_stall, ram_we, ram_adr} !== {2'b11, 8'h20}) begin
      n_fail++; $display("FAIL wr_rd_first: got stall=%b we=%b adr=%h expected 1 1 20", host_stall, ram_we, ram_adr); end
    gm[8'h20] = 8'h5A;
    @(negedge clk); host_wr_en = 0; #1;
    n_tests++; if ({host_stall, ram_we, host_rd_valid} !== 3'b000) begin
      n_fail++; $display("FAIL wr_rd_second: got stall=%b we=%b valid=%b expected 0 0 0", host_stall, ram_we, host_rd_valid); end
    @(negedge clk); host_rd_en = 0;
    n_tests++; if ({host_rd_valid, host_rd_data} !== {1'b1, 8'h5A}) begin
      n_fail++; $display("FAIL wr_rd_return: got valid=%b data=%h expected 1 5a", host_rd_valid, host_rd_data); end
  endtask

  task automatic test_prefill();
    logic [7:0] a, v, ed;
    bit have;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); v = 8'($urandom);
      host_wr_en = 1; host_wr_adr = 8'(i); host_wr_data = v; gm[i] = v;
    end
    @(negedge clk); host_wr_en = 0;
    have = 0; ed = 0;
    for (int i = 0; i < 17; i++) begin
      if (i > 0) @(negedge clk);
      if (have) begin
        n_tests++; if ({host_rd_valid, host_rd_data} !== {1'b1, ed}) begin
          n_fail++; $display("FAIL prefill_read: got valid=%b data=%h expected 1 %h", host_rd_valid, host_rd_data, ed); end
      end
      have = (i < 16);
      a = 8'($urandom_range(0, 15));
      host_rd_en = have; host_rd_adr = a; ed = gm[a];
    end
    host_rd_en = 0;
  endtask

  task automatic test_run_basic();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    n_tests++; if ({eng_start, finished} !== 2'b10) begin
      n_fail++; $display("FAIL launch_pulse: got start=%b finished=%b expected 1 0", eng_start, finished); end
    @(negedge clk);
    n_tests++; if (eng_start !== 1'b0) begin
      n_fail++; $display("FAIL launch_one_cycle: got eng_start=%b expected 0", eng_start); end
    repeat (3) @(negedge clk);
    eng_done = 1; eng_result_base = 8'h14; eng_result_count = 8'h03;
    @(negedge clk); eng_done = 0; eng_result_base = 0; eng_result_count = 0;
    exp_base = 8'h14; exp_count = 8'h03;
    n_tests++; if ({finished, timeout_err, rba, rwc} !== {2'b10, 8'h14, 8'h03}) begin
      n_fail++; $display("FAIL run_done: got fin=%b to=%b base=%h cnt=%h expected 1 0 14 03", finished, timeout_err, rba, rwc); end
    @(negedge clk);
    n_tests++; if (finished !== 1'b1) begin
      n_fail++; $display("FAIL finished_held: got %b expected 1", finished); end
  endtask

  task automatic test_contention();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    @(negedge clk);
    eng_req = 1; eng_we = 0; eng_adr = 8'h05; host_rd_en = 1; host_rd_adr = 8'h20; #1;
    n_tests++; if ({eng_gnt, host_stall, ram_adr} !== {2'b11, 8'h05}) begin
      n_fail++; $display("FAIL contend_eng_wins: got gnt=%b stall=%b adr=%h expected 1 1 05", eng_gnt, host_stall, ram_adr); end
    @(negedge clk); eng_req = 0;
    n_tests++; if ({eng_rd_valid, host_rd_valid, eng_rd_data} !== {2'b10, gm[5]}) begin
      n_fail++; $display("FAIL contend_eng_return: got ev=%b hv=%b data=%h expected 1 0 %h", eng_rd_valid, host_rd_valid, eng_rd_data, gm[5]); end
    #1;
    n_tests++; if ({eng_gnt, host_stall, ram_adr} !== {2'b00, 8'h20}) begin
      n_fail++; $display("FAIL contend_host_grant: got gnt=%b stall=%b adr=%h expected 0 0 20", eng_gnt, host_stall, ram_adr); end
    @(negedge clk); host_rd_en = 0;
    n_tests++; if ({host_rd_valid, eng_rd_valid, host_rd_data} !== {2'b10, gm[8'h20]}) begin
      n_fail++; $display("FAIL contend_host_return: got hv=%b ev=%b data=%h expected 1 0 %h", host_rd_valid, eng_rd_valid, host_rd_data, gm[8'h20]); end
    eng_done = 1; eng_result_base = 8'h40; eng_result_count = 8'h08;
    @(negedge clk); eng_done = 0;
    exp_base = 8'h40; exp_count = 8'h08;
    n_tests++; if ({finished, rba, rwc} !== {1'b1, 8'h40, 8'h08}) begin
      n_fail++; $display("FAIL contend_done: got fin=%b base=%h cnt=%h expected 1 40 08", finished, rba, rwc); end
  endtask

  task automatic test_done_in_launch();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0; eng_done = 1; eng_result_base = 8'h5C; eng_result_count = 8'h21;
    n_tests++; if (eng_start !== 1'b1) begin
      n_fail++; $display("FAIL dil_launch: got eng_start=%b expected 1", eng_start); end
    @(negedge clk); eng_done = 0;
    exp_base = 8'h5C; exp_count = 8'h21;
    n_tests++; if ({finished, timeout_err, eng_start, rba, rwc} !== {3'b100, 8'h5C, 8'h21}) begin
      n_fail++; $display("FAIL dil_done: got fin=%b to=%b st=%b base=%h cnt=%h expected 1 0 0 5c 21", finished, timeout_err, eng_start, rba, rwc); end
  endtask

  task automatic test_timeout();
    int cnt, seen;
    bit done;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    cnt = 0; seen = 0; done = 0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      start = (i == 3);
      if (finished) done = 1;
      else begin cnt++; if (eng_start) seen++; end
    end
    start = 0;
    n_tests++; if (done !== 1'b1) begin
      n_fail++; $display("FAIL timeout_reached: got done=%b expected 1 within 64 cycles", done); end
    n_tests++; if (cnt != TO) begin
      n_fail++; $display("FAIL timeout_cycles: got %0d RUN cycles expected %0d", cnt, TO); end
    n_tests++; if (seen != 0) begin
      n_fail++; $display("FAIL start_ignored_in_run: got %0d launches expected 0", seen); end
    n_tests++; if ({timeout_err, rba, rwc} !== {1'b1, exp_base, exp_count}) begin
      n_fail++; $display("FAIL timeout_state: got to=%b base=%h cnt=%h expected 1 %h %h", timeout_err, rba, rwc, exp_base, exp_count); end
  endtask

  // Checks the read issued last cycle, then (if drive_new) issues fresh random traffic.
  task automatic rand_traffic(input bit eng_owns, input bit drive_new);
    logic er, ew, hw, hr;
    logic [7:0] ea, ewd, hwa, hwd, hra, exp_adr, exp_wd;
    logic [2:0] exp_ctl;
    bit op;
    n_tests++; if ({host_rd_valid, eng_rd_valid} !== {pend_kind == 1, pend_kind == 2}) begin
      n_fail++; $display("FAIL rand_valid: got hv=%b ev=%b expected owner kind %0d", host_rd_valid, eng_rd_valid, pend_kind); end
    if (pend_kind == 1) begin
      n_tests++; if (host_rd_data !== pend_data) begin
        n_fail++; $display("FAIL rand_host_data: got %h expected %h", host_rd_data, pend_data); end
    end
    if (pend_kind == 2) begin
      n_tests++; if (eng_rd_data !== pend_data) begin
        n_fail++; $display("FAIL rand_eng_data: got %h expected %h", eng_rd_data, pend_data); end
    end
    pend_kind = 0;
    if (!drive_new) begin
      host_wr_en = 0; host_rd_en = 0; eng_req = 0; eng_we = 0;
      return;
    end
    er = 1'($urandom); ew = 1'($urandom); hw = 1'($urandom); hr = 1'($urandom);
    ea = 8'($urandom_range(0, 15)); hwa = 8'($urandom_range(0, 15)); hra = 8'($urandom_range(0, 15));
    ewd = 8'($urandom); hwd = 8'($urandom);
    eng_req = er; eng_we = ew; eng_adr = ea; eng_wdata = ewd;
    host_wr_en = hw; host_wr_adr = hwa; host_wr_data = hwd; host_rd_en = hr; host_rd_adr = hra;
    #1;
    op = 1; exp_wd = 0; exp_adr = 0;
    if (eng_owns && er) begin
      exp_ctl = {1'b1, hw | hr, ew}; exp_adr = ea; exp_wd = ewd;
      if (ew) gm[ea] = ewd; else begin pend_kind = 2; pend_data = gm[ea]; end
    end else if (hw) begin
      exp_ctl = {1'b0, hr, 1'b1}; exp_adr = hwa; exp_wd = hwd; gm[hwa] = hwd;
    end else if (hr) begin
      exp_ctl = 3'b000; exp_adr = hra; pend_kind = 1; pend_data = gm[hra];
    end else begin
      exp_ctl = 3'b000; op = 0;
    end
    n_tests++; if ({eng_gnt, host_stall, ram_we} !== exp_ctl) begin
      n_fail++; $display("FAIL rand_grant: got gnt/stall/we=%b expected %b (eng_owns=%b)", {eng_gnt, host_stall, ram_we}, exp_ctl, eng_owns); end
    if (op) begin
      n_tests++; if (ram_adr !== exp_adr) begin
        n_fail++; $display("FAIL rand_adr: got %h expected %h", ram_adr, exp_adr); end
    end
    if (exp_ctl[0]) begin
      n_tests++; if (ram_wdata !== exp_wd) begin
        n_fail++; $display("FAIL rand_wdata: got %h expected %h", ram_wdata, exp_wd); end
    end
  endtask

  task automatic test_random_runs();
    int d;
    logic [7:0] nb, nc;
    for (int r = 0; r < 12; r++) begin
      d = (r == 0) ? TO - 1 : $urandom_range(0, 19);
      nb = 8'($urandom); nc = 8'($urandom);
      pend_kind = 0;
      for (int j = 0; j < 3; j++) begin @(negedge clk); rand_traffic(1'b0, 1'b1); end
      @(negedge clk); rand_traffic(1'b0, 1'b0);
      start = 1;
      @(negedge clk); start = 0;
      n_tests++; if ({eng_start, finished, timeout_err} !== 3'b100) begin
        n_fail++; $display("FAIL rand_launch: got st/fin/to=%b expected 100", {eng_start, finished, timeout_err}); end
      for (int k = 0; k < TO; k++) begin
        @(negedge clk);
        n_tests++; if (finished !== 1'b0) begin
          n_fail++; $display("FAIL rand_early_finish: got %b expected 0 at RUN cycle %0d", finished, k); end
        eng_done = (k == d); eng_result_base = nb; eng_result_count = nc;
        rand_traffic(1'b1, 1'b1);
        if (k == d) break;
      end
      @(negedge clk); eng_done = 0;
      rand_traffic(1'b1, 1'b0);
      if (d < TO) begin exp_base = nb; exp_count = nc; end
      n_tests++; if ({finished, timeout_err, rba, rwc} !== {1'b1, d >= TO, exp_base, exp_count}) begin
        n_fail++; $display("FAIL rand_run_end: got fin=%b to=%b base=%h cnt=%h expected 1 %b %h %h (d=%0d)", finished, timeout_err, rba, rwc, d >= TO, exp_base, exp_count, d); end
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    @(negedge clk);
    eng_req = 1; eng_we = 0; eng_adr = 8'h03; reset = 1; #1;
    n_tests++; if (eng_gnt !== 1'b1) begin
      n_fail++; $display("FAIL mid_run_read_issued: got gnt=%b expected 1", eng_gnt); end
    @(negedge clk); reset = 0;
    n_tests++; if ({finished, timeout_err, eng_start, host_rd_valid, eng_rd_valid, rba, rwc} !== 21'h0) begin
      n_fail++; $display("FAIL mid_run_reset_regs: got fin=%b to=%b st=%b hv=%b ev=%b base=%h cnt=%h expected all 0", finished, timeout_err, eng_start, host_rd_valid, eng_rd_valid, rba, rwc); end
    #1;
    n_tests++; if ({eng_gnt, host_stall, ram_we, ram_adr} !== 11'h0) begin
      n_fail++; $display("FAIL mid_run_reset_idle: got gnt=%b stall=%b we=%b adr=%h expected 0 0 0 00", eng_gnt, host_stall, ram_we, ram_adr); end
    eng_req = 0;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got no finish expected finish before 2ms");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_host_basic();
    test_wr_rd_together();
    test_prefill();
    test_run_basic();
    test_contention();
    test_done_in_launch();
    test_timeout();
    test_random_runs();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
